// File: rtl/jfpjc_pkg.sv
// jfpjc_pkg: shared scheduler state encoding and the word-to-byte pacing ratio helper
package jfpjc_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ADVANCE} state_t;
  function automatic int calc_ratio(input int in_width, input int out_width);
    return in_width / out_width;
  endfunction
endpackage

// File: rtl/mcu_schedule_counter.sv
// mcu_schedule_counter: MCU block scheduler; in clock/nreset/enable/cfg_blocks/accept_last, out state/cur_comp/mcu_done
module mcu_schedule_counter
  import jfpjc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 3,
  parameter int CW      = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     enable,
  input  logic [NUM_REQ*CNT_W-1:0] cfg_blocks,
  input  logic                     accept_last,
  output state_t                   state,
  output logic [CW-1:0]            cur_comp,
  output logic                     mcu_done
);
  logic [NUM_REQ*CNT_W-1:0] shadow;
  logic [CNT_W-1:0] blk_cnt, blk_inc, cur_cnt;
  logic [CW-1:0] nxt;
  logic wrap, cfg_nz;
  function automatic logic [CW-1:0] first_nz(input logic [NUM_REQ*CNT_W-1:0] c);
    first_nz = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (c[i*CNT_W +: CNT_W] != '0) first_nz = CW'(i);
  endfunction
  always_comb begin
    cur_cnt = shadow[cur_comp*CNT_W +: CNT_W];
    blk_inc = blk_cnt + CNT_W'(1);
    wrap    = cur_comp == CW'(NUM_REQ - 1);
    nxt     = wrap ? '0 : cur_comp + CW'(1);
    cfg_nz  = |cfg_blocks;
  end
  always_ff @(posedge clock) begin
    if (nreset) begin
      state    <= IDLE;
      shadow   <= '0;
      cur_comp <= '0;
      blk_cnt  <= '0;
      mcu_done <= 1'b0;
    end else begin
      mcu_done <= 1'b0;
      case (state)
        IDLE: if (enable && cfg_nz) begin
          shadow   <= cfg_blocks;
          cur_comp <= first_nz(cfg_blocks);
          blk_cnt  <= '0;
          state    <= GRANT;
        end
        GRANT: if (accept_last) begin
          blk_cnt <= blk_inc == cur_cnt ? '0 : blk_inc;
          state   <= blk_inc == cur_cnt ? ADVANCE : GRANT;
        end
        ADVANCE: if (wrap) begin
          // MCU boundary: the fresh config decides whether to continue and where
          mcu_done <= 1'b1;
          shadow   <= cfg_blocks;
          cur_comp <= '0;
          state    <= (!enable || !cfg_nz) ? IDLE :
                      cfg_blocks[CNT_W-1:0] != '0 ? GRANT : ADVANCE;
        end else begin
          cur_comp <= nxt;
          state    <= shadow[nxt*CNT_W +: CNT_W] != '0 ? GRANT : ADVANCE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/jpeg_stream_arbiter.sv
// jpeg_stream_arbiter: MCU-ordered, paced mux of component streams into the width adapter; ports req_*/out_*/cur_comp/mcu_done
module jpeg_stream_arbiter
  import jfpjc_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_W     = 3,
  parameter int CW        = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        enable,
  input  logic [NUM_REQ*CNT_W-1:0]    cfg_blocks,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [IN_WIDTH-1:0]         out_data,
  output logic [CW-1:0]               cur_comp,
  output logic                        mcu_done
);
  localparam int RATIO = calc_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int PW    = RATIO > 1 ? $clog2(RATIO) : 1;
  state_t state;
  logic [PW-1:0] pace_cnt;
  logic accept, accept_last;
  mcu_schedule_counter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .CW(CW)) u_sched (
    .clock       (clock),
    .nreset      (nreset),
    .enable      (enable),
    .cfg_blocks  (cfg_blocks),
    .accept_last (accept_last),
    .state       (state),
    .cur_comp    (cur_comp),
    .mcu_done    (mcu_done)
  );
  always_comb begin
    req_ready   = (state == GRANT && pace_cnt == '0) ? NUM_REQ'(1) << cur_comp : '0;
    accept      = |(req_valid & req_ready);
    accept_last = accept && req_last[cur_comp];
  end
  always_ff @(posedge clock) begin
    if (nreset) begin
      pace_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // the adapter cannot stall, so each word reserves RATIO cycles of its time
      pace_cnt  <= accept ? PW'(RATIO - 1) : pace_cnt != '0 ? pace_cnt - PW'(1) : pace_cnt;
      out_valid <= accept;
      out_data  <= accept ? req_data[cur_comp*IN_WIDTH +: IN_WIDTH] : out_data;
    end
  end
endmodule
